// File: rtl/mips_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// mips_pkg : shared fetch-stage types, constants and jump-target helper
// Revision 1.0
// ----------------------------------------------------------------------
package mips_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP    = 32'h0000_0000;
   localparam logic [31:0] PC_INC = 32'd4;

   // J-type target: upper nibble of PC+4 of the jump, 26-bit index, word aligned
   function automatic logic [31:0] jump_target(input logic [3:0]  pc_hi,
                                               input logic [25:0] idx);
      return {pc_hi, idx, 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/if_skid_buf.sv
`default_nettype none
// ----------------------------------------------------------------------
// if_skid_buf : one-entry {instruction, PC+4} holding buffer for IF/ID
// Revision 1.0
// ----------------------------------------------------------------------
module if_skid_buf
   import mips_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic        clear_i,
   input  logic [31:0] data_i,
   input  logic [31:0] addr_i,
   output logic        valid_o,
   output logic [31:0] data_o,
   output logic [31:0] addr_o
);

   logic        valid_q, valid_d;
   logic [31:0] data_q,  data_d;
   logic [31:0] addr_q,  addr_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      addr_d  = addr_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         addr_d  = addr_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= 1'b0;
         data_q  <= NOP;
         addr_q  <= 32'h0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign addr_o  = addr_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------
// if_fetch_unit : PC, req/ack instruction fetch, IF/ID output with skid
// Revision 1.0
// ----------------------------------------------------------------------
module if_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = NOP
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        branch_i,
   input  logic [31:0] branch_addr_i,
   input  logic        jump_i,
   input  logic [25:0] jump_addr_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        inst_valid_o,
   output logic        flush_o
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  req_addr_q, req_addr_d;
   logic [31:0]  inst_q, inst_d;
   logic [31:0]  inst_addr_q, inst_addr_d;
   logic         inst_valid_q, inst_valid_d;
   logic         flush_q, flush_d;

   logic         redirect, accept;
   logic [31:0]  target, pc_inc, ret_addr;
   logic         skid_valid, skid_load, skid_clear;
   logic [31:0]  skid_data, skid_addr;

   assign redirect = (branch_i | jump_i) & ~stall_i;
   assign target   = branch_i ? branch_addr_i : jump_target(inst_addr_q[31:28], jump_addr_i);
   // Data counts only in REQ; a same-cycle redirect makes it wrong-path
   assign accept   = (state_q == ST_REQ) & imem_ack_i & ~redirect;
   assign pc_inc   = pc_q + PC_INC;
   assign ret_addr = req_addr_q + PC_INC;

   assign skid_load  = accept & stall_i;
   assign skid_clear = redirect | (~stall_i & skid_valid);

   if_skid_buf u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .data_i  (imem_data_i),
      .addr_i  (ret_addr),
      .valid_o (skid_valid),
      .data_o  (skid_data),
      .addr_o  (skid_addr)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (!skid_valid && !redirect) begin
               state_d    = ST_REQ;
               req_addr_d = pc_q;
            end
         end
         ST_REQ: begin
            if (accept) begin
               if (!stall_i) req_addr_d = pc_inc;
               else          state_d    = ST_IDLE;
            end else if (redirect) begin
               state_d = imem_ack_i ? ST_IDLE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (imem_ack_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (redirect)    pc_d = target;
      else if (accept) pc_d = pc_inc;
   end

   always_comb begin
      inst_d       = inst_q;
      inst_addr_d  = inst_addr_q;
      inst_valid_d = inst_valid_q;
      flush_d      = redirect;
      if (redirect) begin
         inst_valid_d = 1'b0;
         inst_d       = NOP_INST;
      end else if (!stall_i) begin
         if (skid_valid) begin
            inst_d       = skid_data;
            inst_addr_d  = skid_addr;
            inst_valid_d = 1'b1;
         end else if (accept) begin
            inst_d       = imem_data_i;
            inst_addr_d  = ret_addr;
            inst_valid_d = 1'b1;
         end else begin
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         req_addr_q   <= 32'h0;
         inst_q       <= NOP_INST;
         inst_addr_q  <= 32'h0;
         inst_valid_q <= 1'b0;
         flush_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_addr_q   <= req_addr_d;
         inst_q       <= inst_d;
         inst_addr_q  <= inst_addr_d;
         inst_valid_q <= inst_valid_d;
         flush_q      <= flush_d;
      end
   end

   assign imem_req_o   = (state_q != ST_IDLE);
   assign imem_addr_o  = req_addr_q;
   assign inst_o       = inst_q;
   assign inst_addr_o  = inst_addr_q;
   assign inst_valid_o = inst_valid_q;
   assign flush_o      = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_if_fetch_unit : directed table, corner sequences and random run
// Revision 1.0
// ----------------------------------------------------------------------
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, br = 1'b0, jp = 1'b0, ack = 1'b0;
   logic [31:0] baddr = 32'h0, data = 32'h0;
   logic [25:0] jaddr = 26'h0;
   logic        imem_req, inst_valid, flush;
   logic [31:0] imem_addr, inst, inst_addr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   if_fetch_unit dut (
      .clk_i         (clk),
      .rst_i         (rst_n),
      .stall_i       (stall),
      .branch_i      (br),
      .branch_addr_i (baddr),
      .jump_i        (jp),
      .jump_addr_i   (jaddr),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_ack_i    (ack),
      .imem_data_i   (data),
      .inst_o        (inst),
      .inst_addr_o   (inst_addr),
      .inst_valid_o  (inst_valid),
      .flush_o       (flush)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: outstanding-request flags plus a queue of held results
   typedef struct packed {
      logic [31:0] d;
      logic [31:0] a;
   } ent_t;

   logic        m_busy, m_disc, m_valid, m_flush;
   logic [31:0] m_pc, m_addr, m_inst, m_iaddr;
   ent_t        held[$];

   task automatic model_reset();
      m_busy = 1'b0; m_disc = 1'b0; m_valid = 1'b0; m_flush = 1'b0;
      m_pc = 32'h0; m_addr = 32'h0; m_inst = 32'h0; m_iaddr = 32'h0;
      held.delete();
   endtask

   task automatic model_step();
      logic        redir, take;
      logic [31:0] tgt, pc_now;
      int          held_before;
      ent_t        e;
      redir       = (br | jp) & ~stall;
      tgt         = br ? baddr : {m_iaddr[31:28], jaddr, 2'b00};
      take        = m_busy && !m_disc && ack && !redir;
      pc_now      = m_pc;
      held_before = held.size();
      m_flush     = redir;
      if (redir) begin
         m_valid = 1'b0; m_inst = 32'h0; held.delete();
      end else if (!stall) begin
         if (held.size() > 0) begin
            e = held.pop_front();
            m_inst = e.d; m_iaddr = e.a; m_valid = 1'b1;
         end else if (take) begin
            m_inst = data; m_iaddr = m_addr + 32'd4; m_valid = 1'b1;
         end else begin
            m_valid = 1'b0; m_inst = 32'h0;
         end
      end else if (take) begin
         held.push_back({data, m_addr + 32'd4});
      end
      if (m_busy) begin
         if (ack) begin
            if (take && !stall) m_addr = pc_now + 32'd4;
            else                m_busy = 1'b0;
            m_disc = 1'b0;
         end else if (redir) begin
            m_disc = 1'b1;
         end
      end else if (held_before == 0 && !redir) begin
         m_busy = 1'b1; m_disc = 1'b0; m_addr = pc_now;
      end
      m_pc = redir ? tgt : (take ? pc_now + 32'd4 : pc_now);
   endtask

   task automatic step(input logic s, input logic b, input logic j, input logic a,
                       input logic [31:0] ba, input logic [25:0] ja);
      @(negedge clk);
      stall = s; br = b; jp = j; ack = a; baddr = ba; jaddr = ja;
      data  = m_addr ^ 32'hA5A5_0000;
      @(posedge clk);
      model_step();
      #1;
      chk1("model imem_req", imem_req, m_busy);
      chk ("model imem_addr", imem_addr, m_addr);
      chk1("model inst_valid", inst_valid, m_valid);
      chk ("model inst", inst, m_inst);
      chk ("model inst_addr", inst_addr, m_iaddr);
      chk1("model flush", flush, m_flush);
   endtask

   typedef struct {
      logic        s, b, j, a;
      logic [31:0] ba;
      logic [25:0] ja;
      logic        req;
      logic [31:0] addr;
      logic        v;
      logic [31:0] in;
      logic [31:0] ia;
      logic        f;
   } vec_t;

   vec_t tbl [19];

   task automatic setv(input int i, input logic s, input logic b, input logic j, input logic a,
                       input logic [31:0] ba, input logic [25:0] ja, input logic req,
                       input logic [31:0] addr, input logic v, input logic [31:0] in,
                       input logic [31:0] ia, input logic f);
      tbl[i] = '{s, b, j, a, ba, ja, req, addr, v, in, ia, f};
   endtask

   initial begin
      logic [31:0] r;
      //            s  b  j  a  baddr         jaddr        req addr          v  inst          inst_addr     f
      setv( 0, 0, 0, 0, 1, 32'h0,        26'h0,       1, 32'h0,        0, 32'h0,        32'h0,        0);
      setv( 1, 0, 0, 0, 1, 32'h0,        26'h0,       1, 32'h4,        1, 32'hA5A50000, 32'h4,        0);
      setv( 2, 0, 0, 0, 1, 32'h0,        26'h0,       1, 32'h8,        1, 32'hA5A50004, 32'h8,        0);
      setv( 3, 1, 0, 0, 1, 32'h0,        26'h0,       0, 32'h8,        1, 32'hA5A50004, 32'h8,        0);
      setv( 4, 1, 0, 0, 0, 32'h0,        26'h0,       0, 32'h8,        1, 32'hA5A50004, 32'h8,        0);
      setv( 5, 1, 0, 0, 0, 32'h0,        26'h0,       0, 32'h8,        1, 32'hA5A50004, 32'h8,        0);
      setv( 6, 0, 0, 0, 0, 32'h0,        26'h0,       0, 32'h8,        1, 32'hA5A50008, 32'hC,        0);
      setv( 7, 0, 0, 0, 0, 32'h0,        26'h0,       1, 32'hC,        0, 32'h0,        32'hC,        0);
      setv( 8, 0, 1, 0, 1, 32'h100,      26'h0,       0, 32'hC,        0, 32'h0,        32'hC,        1);
      setv( 9, 0, 0, 0, 0, 32'h0,        26'h0,       1, 32'h100,      0, 32'h0,        32'hC,        0);
      setv(10, 0, 0, 0, 1, 32'h0,        26'h0,       1, 32'h104,      1, 32'hA5A50100, 32'h104,      0);
      setv(11, 0, 0, 1, 0, 32'h0,        26'h40,      1, 32'h104,      0, 32'h0,        32'h104,      1);
      setv(12, 0, 0, 0, 0, 32'h0,        26'h0,       1, 32'h104,      0, 32'h0,        32'h104,      0);
      setv(13, 0, 0, 0, 1, 32'h0,        26'h0,       0, 32'h104,      0, 32'h0,        32'h104,      0);
      setv(14, 0, 0, 0, 0, 32'h0,        26'h0,       1, 32'h100,      0, 32'h0,        32'h104,      0);
      setv(15, 0, 1, 1, 1, 32'h200,      26'h3FFFFFF, 0, 32'h100,      0, 32'h0,        32'h104,      1);
      setv(16, 0, 0, 0, 0, 32'h0,        26'h0,       1, 32'h200,      0, 32'h0,        32'h104,      0);
      setv(17, 1, 1, 0, 0, 32'h300,      26'h0,       1, 32'h200,      0, 32'h0,        32'h104,      0);
      setv(18, 0, 0, 0, 1, 32'h0,        26'h0,       1, 32'h204,      1, 32'hA5A50200, 32'h204,      0);

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk1("reset imem_req", imem_req, 1'b0);
      chk ("reset imem_addr", imem_addr, 32'h0);
      chk1("reset inst_valid", inst_valid, 1'b0);
      chk ("reset inst", inst, 32'h0);
      chk ("reset inst_addr", inst_addr, 32'h0);
      chk1("reset flush", flush, 1'b0);
      #1 rst_n = 1'b1;

      // Streaming, stall into skid, branch with ack, jump drain, both-asserted, stalled branch
      for (int i = 0; i < 19; i++) begin
         step(tbl[i].s, tbl[i].b, tbl[i].j, tbl[i].a, tbl[i].ba, tbl[i].ja);
         chk1($sformatf("vec%0d imem_req", i), imem_req, tbl[i].req);
         chk ($sformatf("vec%0d imem_addr", i), imem_addr, tbl[i].addr);
         chk1($sformatf("vec%0d inst_valid", i), inst_valid, tbl[i].v);
         chk ($sformatf("vec%0d inst", i), inst, tbl[i].in);
         chk ($sformatf("vec%0d inst_addr", i), inst_addr, tbl[i].ia);
         chk1($sformatf("vec%0d flush", i), flush, tbl[i].f);
      end

      // Jump using inst_addr 0x1000_0008 while a request is outstanding
      step(0, 1, 0, 0, 32'h1000_0004, 26'h0);
      step(0, 0, 0, 1, 32'h0, 26'h0);
      step(0, 0, 0, 0, 32'h0, 26'h0);
      chk("jump prep req addr", imem_addr, 32'h1000_0004);
      step(0, 0, 0, 1, 32'h0, 26'h0);
      chk("jump prep inst_addr", inst_addr, 32'h1000_0008);
      step(0, 0, 1, 0, 32'h0, 26'h40);
      chk1("jump flush", flush, 1'b1);
      step(0, 0, 0, 0, 32'h0, 26'h0);
      step(0, 0, 0, 0, 32'h0, 26'h0);
      chk1("drain req held", imem_req, 1'b1);
      chk ("drain addr held", imem_addr, 32'h1000_0008);
      step(0, 0, 0, 1, 32'h0, 26'h0);
      chk1("drain ack discarded", inst_valid, 1'b0);
      step(0, 0, 0, 0, 32'h0, 26'h0);
      chk("jump target fetch", imem_addr, 32'h1000_0100);

      // PC wrap at the top of the address space
      step(0, 1, 0, 0, 32'hFFFF_FFFC, 26'h0);
      step(0, 0, 0, 1, 32'h0, 26'h0);
      step(0, 0, 0, 0, 32'h0, 26'h0);
      chk("wrap fetch addr", imem_addr, 32'hFFFF_FFFC);
      step(0, 0, 0, 1, 32'h0, 26'h0);
      chk ("wrap next addr", imem_addr, 32'h0);
      chk ("wrap inst_addr", inst_addr, 32'h0);
      chk ("wrap inst", inst, 32'h5A5A_FFFC);

      // Asynchronous reset in the middle of a request
      #3 rst_n = 1'b0;
      ack = 1'b1;
      #1;
      chk1("async imem_req", imem_req, 1'b0);
      chk ("async imem_addr", imem_addr, 32'h0);
      chk1("async inst_valid", inst_valid, 1'b0);
      chk ("async inst", inst, 32'h0);
      chk ("async inst_addr", inst_addr, 32'h0);
      model_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;
      step(0, 0, 0, 1, 32'h0, 26'h0);
      chk("post-reset first fetch", imem_addr, 32'h0);

      for (int i = 0; i < 600; i++) begin
         logic s, b, j, a;
         logic [31:0] ba;
         r  = $urandom;
         s  = ($urandom_range(0, 3) == 0);
         b  = ($urandom_range(0, 9) == 0);
         j  = ($urandom_range(0, 9) == 0);
         a  = ($urandom_range(0, 1) == 1);
         ba = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {r[31:2], 2'b00};
         r  = $urandom;
         step(s, b, j, a, ba, r[25:0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Holds the PC and issues requests on a req/ack instruction-memory port.
- Delivers {PC+4, instruction, valid} to IF/ID and absorbs hazard stalls with a one-entry skid buffer.
- Applies branch and jump redirects resolved in ID, and raises the IF/ID flush.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0000, instruction value driven on inst_o when no valid instruction is present.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- stall_i  in  1  hazard-detect hold; IF/ID does not consume this cycle.
- branch_i  in  1  taken branch resolved in ID.
- branch_addr_i  in  32  branch target.
- jump_i  in  1  jump decoded in ID.
- jump_addr_i  in  26  jump index field, instr[25:0].
- imem_req_o  out  1  memory request; held high until ack.
- imem_addr_o  out  32  word address of the request; stable while req=1.
- imem_ack_i  in  1  data valid for the current request.
- imem_data_i  in  32  returned instruction.
- inst_o  out  32  instruction to IF/ID.
- inst_addr_o  out  32  PC+4 of inst_o.
- inst_valid_o  out  1  inst_o is a real instruction.
- flush_o  out  1  one-cycle flush pulse to IF/ID.

Behaviour:
- Reset (async, rst_i=0):
  - pc=RESET_PC; state=IDLE.
  - imem_req_o=0, imem_addr_o=0.
  - inst_o=NOP_INST, inst_addr_o=0, inst_valid_o=0.
  - Skid buffer empty; flush_o=0.
  - Deassertion mid-request: the in-flight ack is ignored, because the request was dropped by reset.
- States:
  - IDLE: no request.
  - REQ: request pending at req_addr.
  - DRAIN: request pending, result to be discarded.
- imem_req_o=1 in REQ and DRAIN. imem_addr_o=req_addr register, loaded from pc on entry to REQ.
- Redirect:
  - redirect = (branch_i | jump_i) & ~stall_i; ignored while stall_i=1.
  - branch_i has priority over jump_i if both are asserted.
  - Jump target = {inst_addr_o[31:28], jump_addr_i, 2'b00}.
- Transitions:
  - IDLE -> REQ when skid empty and no redirect; req_addr<=pc.
  - REQ & ack & no redirect:
    - Data is accepted; pc<=pc+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
    - If the skid stays empty, remain in REQ with req_addr<=pc+4, giving back-to-back fetch at 1 instr/cycle.
    - Otherwise go to IDLE.
  - REQ & ~ack & redirect -> DRAIN. REQ & ack & redirect -> IDLE, data discarded.
  - DRAIN & ack -> IDLE, data discarded. A redirect in DRAIN only updates pc.
- Output register and skid buffer:
  - stall_i=0: out <= skid if valid (skid cleared). Else out <= accepted ack data, with inst_addr_o=req_addr+4. Else out becomes a bubble (valid=0, inst_o=NOP_INST).
  - stall_i=1: out holds. An accepted ack goes to the skid; no new request is issued while the skid is full.
- Redirect effects, same edge:
  - pc<=target; out valid<=0, inst_o<=NOP_INST; skid cleared.
  - flush_o=1 for exactly the following cycle.
- Latency: ack in cycle N -> inst_valid_o=1 in N+1 when not stalled.

Decomposition:
- Shared package (mips_pkg) holds:
  - Fetch state enum {IDLE, REQ, DRAIN}.
  - NOP constant.
  - PC_INC=4.
  - Jump-target helper function.
- Sub-module if_skid_buf: one-entry buffer of {data, addr}, valid/clear/load. Everything else lives in the top module.

Test Plan:
1. Reset release, imem acks every cycle with data=addr ^ 32'hA5A5_0000 -> imem_addr 0,4,8,...; inst_valid_o=1 from the second ack onward, inst_addr_o 4,8,12.
2. stall_i=1 for 3 cycles during continuous acks -> the stalled output holds; one extra instruction lands in the skid; imem_req_o drops. After release, the skid entry is output next with no loss or duplication.
3. branch_i=1, branch_addr_i=32'h0000_0100 with the ack in the same cycle -> that ack's data is dropped; flush_o pulses one cycle; the next imem_addr_o=32'h100.
4. jump_i=1, jump_addr_i=26'h000_0040, inst_addr_o=32'h1000_0008, with an outstanding request and ack 3 cycles later -> DRAIN holds the old address until ack, which is discarded; the next request goes to 32'h1000_0100.
5. branch_i and jump_i both asserted -> the branch target is used. branch_i asserted with stall_i=1 -> ignored, no flush.
6. pc=32'hFFFF_FFFC fetched -> next imem_addr_o=0. Async rst_i low mid-REQ -> all outputs at reset values immediately.
